// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road (main/sub) traffic-light sequencer.
//   A prescaler divides clk_i into a one-second tick. Day mode cycles
//   MAIN_GREEN -> MAIN_YELLOW -> SUB_GREEN -> SUB_YELLOW. Night mode flashes
//   both yellow lamps and blanks the time display.
// Ports:
//   clk_i             system clock, rising edge
//   rst_i             synchronous reset, active-high
//   night_i           level, 1 = night mode (flashing yellow, display off)
//   hold_i            level, 1 = freeze countdown and phase
//   main_light_o      main road lamps {red,yellow,green}
//   sub_light_o       sub road lamps {red,yellow,green}
//   main_rest_time_o  main road seconds until its lamp next changes
//   sub_rest_time_o   sub road seconds until its lamp next changes
//   dis_en_o          1 = display shows rest times, 0 = blank
module traffic_light_ctrl #(
  parameter int unsigned CLK_DIV  = 50_000_000,
  parameter int unsigned MAIN_G_T = 25,
  parameter int unsigned SUB_G_T  = 15,
  parameter int unsigned YEL_T    = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       night_i,
  input  logic       hold_i,
  output logic [2:0] main_light_o,
  output logic [2:0] sub_light_o,
  output logic [4:0] main_rest_time_o,
  output logic [4:0] sub_rest_time_o,
  output logic       dis_en_o
);

  localparam int unsigned PreW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(CLK_DIV - 1);
  localparam logic [4:0] MainGT = 5'(MAIN_G_T);
  localparam logic [4:0] SubGT  = 5'(SUB_G_T);
  localparam logic [4:0] YelT   = 5'(YEL_T);

  typedef enum logic [2:0] {
    StMainGreen,
    StMainYellow,
    StSubGreen,
    StSubYellow,
    StNight
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
  logic            flash_q, flash_d;
  logic            tick;

  assign tick = (pre_cnt_q == PreMax);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StMainGreen;
      cnt_q     <= MainGT;
      pre_cnt_q <= '0;
      flash_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_cnt_q <= pre_cnt_d;
      flash_q   <= flash_d;
    end
  end

  // Next-state: night beats hold beats tick. Prescaler keeps running under hold.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flash_d   = flash_q;
    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;

    if (night_i) begin
      if (state_q != StNight) begin
        state_d = StNight;
        cnt_d   = '0;
        flash_d = 1'b0;
      end else if (tick) begin
        flash_d = ~flash_q;
      end
    end else if (state_q == StNight) begin
      // Leaving night is a full restart, same as reset.
      state_d   = StMainGreen;
      cnt_d     = MainGT;
      pre_cnt_d = '0;
      flash_d   = 1'b0;
    end else if (!hold_i && tick) begin
      if (cnt_q > 5'd1) begin
        cnt_d = cnt_q - 5'd1;
      end else begin
        case (state_q)
          StMainGreen: begin
            state_d = StMainYellow;
            cnt_d   = YelT;
          end
          StMainYellow: begin
            state_d = StSubGreen;
            cnt_d   = SubGT;
          end
          StSubGreen: begin
            state_d = StSubYellow;
            cnt_d   = YelT;
          end
          default: begin
            state_d = StMainGreen;
            cnt_d   = MainGT;
          end
        endcase
      end
    end
  end

  // Outputs decode registered state only; a road on red adds the other
  // road's yellow time to its remaining seconds.
  always_comb begin
    main_light_o     = 3'b000;
    sub_light_o      = 3'b000;
    main_rest_time_o = 5'd0;
    sub_rest_time_o  = 5'd0;
    dis_en_o         = 1'b1;
    case (state_q)
      StMainGreen: begin
        main_light_o     = 3'b001;
        sub_light_o      = 3'b100;
        main_rest_time_o = cnt_q;
        sub_rest_time_o  = cnt_q + YelT;
      end
      StMainYellow: begin
        main_light_o     = 3'b010;
        sub_light_o      = 3'b100;
        main_rest_time_o = cnt_q;
        sub_rest_time_o  = cnt_q;
      end
      StSubGreen: begin
        main_light_o     = 3'b100;
        sub_light_o      = 3'b001;
        main_rest_time_o = cnt_q + YelT;
        sub_rest_time_o  = cnt_q;
      end
      StSubYellow: begin
        main_light_o     = 3'b100;
        sub_light_o      = 3'b010;
        main_rest_time_o = cnt_q;
        sub_rest_time_o  = cnt_q;
      end
      default: begin
        main_light_o = {1'b0, flash_q, 1'b0};
        sub_light_o  = {1'b0, flash_q, 1'b0};
        dis_en_o     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
module tb_traffic_light_ctrl;

  localparam int unsigned CD = 4;
  localparam int unsigned MG = 5;
  localparam int unsigned SG = 3;
  localparam int unsigned YT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       night = 1'b0;
  logic       hold = 1'b0;
  logic [2:0] main_light, sub_light;
  logic [4:0] main_rest, sub_rest;
  logic       dis_en;
  logic [16:0] obs;

  int checks = 0;
  int errors = 0;

  localparam logic [16:0] ResetOut = {3'b001, 3'b100, 5'd5, 5'd7, 1'b1};

  traffic_light_ctrl #(
    .CLK_DIV (CD),
    .MAIN_G_T(MG),
    .SUB_G_T (SG),
    .YEL_T   (YT)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .night_i         (night),
    .hold_i          (hold),
    .main_light_o    (main_light),
    .sub_light_o     (sub_light),
    .main_rest_time_o(main_rest),
    .sub_rest_time_o (sub_rest),
    .dis_en_o        (dis_en)
  );

  always #5 clk = ~clk;

  assign obs = {main_light, sub_light, main_rest, sub_rest, dis_en};

  // Reference model: phase index into lamp tables, seconds left, prescaler.
  logic [2:0] mlamp [4];
  logic [2:0] slamp [4];
  int  m_phase = 0;
  int  m_cnt = MG;
  int  m_pre = 0;
  bit  m_night = 1'b0;
  bit  m_flash = 1'b0;

  initial begin
    mlamp[0] = 3'b001; mlamp[1] = 3'b010; mlamp[2] = 3'b100; mlamp[3] = 3'b100;
    slamp[0] = 3'b100; slamp[1] = 3'b100; slamp[2] = 3'b001; slamp[3] = 3'b010;
  end

  function automatic int dur(input int p);
    case (p)
      0: return MG;
      2: return SG;
      default: return YT;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_night <= 1'b0; m_phase <= 0; m_cnt <= MG; m_pre <= 0; m_flash <= 1'b0;
    end else begin
      m_pre <= (m_pre + 1) % CD;
      if (night) begin
        if (!m_night) begin
          m_night <= 1'b1; m_cnt <= 0; m_flash <= 1'b0;
        end else if (m_pre == CD - 1) begin
          m_flash <= !m_flash;
        end
      end else if (m_night) begin
        m_night <= 1'b0; m_phase <= 0; m_cnt <= MG; m_pre <= 0; m_flash <= 1'b0;
      end else if (!hold && m_pre == CD - 1) begin
        if (m_cnt > 1) m_cnt <= m_cnt - 1;
        else begin
          m_phase <= (m_phase + 1) % 4;
          m_cnt   <= dur((m_phase + 1) % 4);
        end
      end
    end
  end

  // Seconds until a road's lamp changes: if the lamp persists into the next
  // phase, that phase's whole duration is added.
  function automatic logic [16:0] model_out();
    int nx, mr, sr;
    if (m_night) return {1'b0, m_flash, 1'b0, 1'b0, m_flash, 1'b0, 5'd0, 5'd0, 1'b0};
    nx = (m_phase + 1) % 4;
    mr = (mlamp[nx] == mlamp[m_phase]) ? m_cnt + dur(nx) : m_cnt;
    sr = (slamp[nx] == slamp[m_phase]) ? m_cnt + dur(nx) : m_cnt;
    return {mlamp[m_phase], slamp[m_phase], 5'(mr), 5'(sr), 1'b1};
  endfunction

  // Safety: never green/yellow on both roads while in day mode.
  always @(negedge clk) begin
    checks++;
    if (dis_en && main_light[1:0] != 2'b00 && sub_light[1:0] != 2'b00) begin
      errors++;
      $display("FAIL safety: main=%b sub=%b required no concurrent go lamps", main_light,
               sub_light);
    end
  end

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; night = 1'b0; hold = 1'b0;
    edges(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== ResetOut) begin
      errors++; $display("FAIL reset_state: got %h required %h", obs, ResetOut);
    end
    checks++;
    if (obs !== model_out()) begin
      errors++; $display("FAIL reset_model: got %h required %h", obs, model_out());
    end
    edges(3);
    checks++;
    if (main_rest !== 5'd5) begin
      errors++; $display("FAIL reset_pre_tick: got %0d required 5", main_rest);
    end
    edges(1);
    checks++;
    if (main_rest !== 5'd4) begin
      errors++; $display("FAIL reset_first_tick: got %0d required 4", main_rest);
    end
  endtask

  task automatic test_free_run();
    int mr [13] = '{5, 4, 3, 2, 1, 2, 1, 5, 4, 3, 2, 1, 5};
    int sr [13] = '{7, 6, 5, 4, 3, 2, 1, 3, 2, 1, 2, 1, 7};
    logic [2:0] ml [13] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010,
                            3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      edges(CD);
      checks++;
      if (main_rest !== 5'(mr[k]) || sub_rest !== 5'(sr[k]) || main_light !== ml[k]) begin
        errors++;
        $display("FAIL free_run tick %0d: got main=%b mr=%0d sr=%0d required main=%b mr=%0d sr=%0d",
                 k, main_light, main_rest, sub_rest, ml[k], mr[k], sr[k]);
      end
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL free_run_model tick %0d: got %h required %h", k, obs, model_out());
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    edges(2 * CD);
    checks++;
    if (main_rest !== 5'd3) begin
      errors++; $display("FAIL hold_setup: got %0d required 3", main_rest);
    end
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      edges(1);
      checks++;
      if (main_rest !== 5'd3 || main_light !== 3'b001 || sub_light !== 3'b100) begin
        errors++;
        $display("FAIL hold_frozen cyc %0d: got mr=%0d main=%b sub=%b required 3 001 100",
                 i, main_rest, main_light, sub_light);
      end
    end
    hold = 1'b0;
    edges(1);
    checks++;
    if (main_rest !== 5'd3) begin
      errors++; $display("FAIL hold_release: got %0d required 3", main_rest);
    end
    edges(1);
    checks++;
    if (main_rest !== 5'd2 || obs !== model_out()) begin
      errors++; $display("FAIL hold_resume: got %h required %h (mr=2)", obs, model_out());
    end
  endtask

  task automatic test_night();
    int toggles = 0;
    logic [2:0] prev;
    do_reset();
    edges(7 * CD);
    checks++;
    if (main_light !== 3'b100 || sub_light !== 3'b001) begin
      errors++; $display("FAIL night_setup: got %b %b required 100 001", main_light, sub_light);
    end
    night = 1'b1;
    edges(1);
    checks++;
    if (obs !== 17'd0) begin
      errors++; $display("FAIL night_entry: got %h required 0", obs);
    end
    prev = main_light;
    for (int i = 0; i < 12; i++) begin
      edges(1);
      if (main_light !== prev) toggles++;
      prev = main_light;
      checks++;
      if (obs !== model_out() || sub_light !== main_light || main_light[2] || main_light[0]) begin
        errors++; $display("FAIL night_flash cyc %0d: got %h required %h", i, obs, model_out());
      end
    end
    checks++;
    if (toggles != 3 || main_light !== 3'b010) begin
      errors++;
      $display("FAIL night_toggles: got %0d lamp=%b required 3 lamp=010", toggles, main_light);
    end
    night = 1'b0;
    edges(1);
    checks++;
    if (obs !== ResetOut) begin
      errors++; $display("FAIL night_exit: got %h required %h", obs, ResetOut);
    end
    edges(CD - 1);
    checks++;
    if (main_rest !== 5'd5) begin
      errors++; $display("FAIL night_exit_pre: got %0d required 5", main_rest);
    end
    edges(1);
    checks++;
    if (main_rest !== 5'd4) begin
      errors++; $display("FAIL night_exit_tick: got %0d required 4", main_rest);
    end
  endtask

  task automatic test_reset_on_tick();
    do_reset();
    edges(11 * CD);
    checks++;
    if (main_light !== 3'b100 || sub_light !== 3'b010 || sub_rest !== 5'd1) begin
      errors++;
      $display("FAIL rst_tick_setup: got %b %b sr=%0d required 100 010 1", main_light,
               sub_light, sub_rest);
    end
    edges(CD - 1);
    rst = 1'b1;
    edges(1);
    rst = 1'b0;
    checks++;
    if (obs !== ResetOut) begin
      errors++; $display("FAIL rst_tick_wins: got %h required %h", obs, ResetOut);
    end
    edges(CD);
    checks++;
    if (main_rest !== 5'd4 || obs !== model_out()) begin
      errors++; $display("FAIL rst_tick_after: got %h required %h", obs, model_out());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 119) == 0) night = ~night;
      hold = ($urandom_range(0, 5) == 0);
      edges(1);
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL random cyc %0d: got %h required %h", i, obs, model_out());
      end
    end
    rst = 1'b0; night = 1'b0; hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_hold();
    test_night();
    test_reset_on_tick();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
